// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states,
// default frame geometry and line levels.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic logic maj3(
    input logic [2:0] v
  );
    return (v[0] & v[1]) |
           (v[0] & v[2]) |
           (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous inputs,
// synchronous active-low reset to RST_VAL.
module rx_sync #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  // Two back-to-back flops; meta may go metastable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/rx_block.sv
// UART receiver: 1 start, DATA_BITS LSB-first, 1 stop.
// Define RX_MAJORITY_EN for 2-of-3 sample voting.
module rx_block
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST =
    BW'(DATA_BITS - 1);

  rx_state_t state;
  rx_state_t nxt;

  logic                 rx_s;
  logic                 rx_prev;
  logic                 line;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic start_det;
  logic tick_half;
  logic tick_full;
  logic bit_last;

  logic cnt_clr;
  logic cnt_inc;
  logic bit_clr;
  logic shift_en;
  logic valid_d;
  logic ferr_d;

  rx_sync #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_s)
  );

`ifdef RX_MAJORITY_EN
  logic [1:0] hist;

  // Last two tick samples; hist[0] doubles as rx_prev
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (clk_en) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign rx_prev = hist[0];
  assign line    = maj3({hist, rx_s});
`else
  // Previous tick sample for falling-edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
    end else if (clk_en) begin
      rx_prev <= rx_s;
    end
  end

  assign line = rx_s;
`endif

  assign start_det = clk_en & rx_prev & ~rx_s;
  assign tick_half = (cnt == HALF);
  assign tick_full = (cnt == FULL);
  assign bit_last  = (bit_cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start_det) nxt = START;
      end
      START: begin
        if (clk_en && tick_half)
          nxt = (line == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (clk_en && tick_full && bit_last)
          nxt = STOP;
      end
      STOP: begin
        if (clk_en && tick_full) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath controls and pulse requests
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = start_det;
      end
      START: begin
        if (clk_en) begin
          cnt_clr = tick_half;
          bit_clr = tick_half;
          cnt_inc = ~tick_half;
        end
      end
      DATA: begin
        if (clk_en) begin
          cnt_clr  = tick_full;
          shift_en = tick_full;
          cnt_inc  = ~tick_full;
        end
      end
      STOP: begin
        if (clk_en) begin
          cnt_clr = tick_full;
          cnt_inc = ~tick_full;
          valid_d = tick_full &
                    (line == STOP_BIT);
          ferr_d  = tick_full &
                    (line != STOP_BIT);
        end
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Tick/bit counters, shifter and output pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rdata     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (shift_en) begin
        shreg <= {line, shreg[DATA_BITS-1:1]};
      end
      if (valid_d) begin
        rdata <= shreg;
      end
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

endmodule

// File: tb/tb_rx_block.sv
// Scoreboard bench for rx_block: random frames,
// directed break/glitch/reset/bad-stop cases.
module tb_rx_block;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clk_en = 1'b0;
  logic          rx_in  = 1'b1;
  logic [DB-1:0] rdata;
  logic          valid;
  logic          frame_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            is_err;
    logic [DB-1:0] data;
  } ev_t;

  ev_t exp_q[$];

  rx_block #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .rx_in     (rx_in),
    .rdata     (rdata),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Tick every 3..5 clocks: random stalls between ticks
  initial begin
    forever begin
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (!clk_en);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      rx_in = 1'b1;
    end
  endtask

  // Model: good stop -> byte (bit 2 forced by an
  // unvoted mid-bit glitch), bad stop -> error event.
  task automatic send(
    input logic [DB-1:0] b,
    input bit            stop,
    input bit            glitch
  );
    ev_t  e;
    logic v;
    e.is_err = !stop;
    e.data   = b;
`ifndef RX_MAJORITY_EN
    if (glitch) e.data[2] = 1'b1;
`endif
    exp_q.push_back(e);
    for (int i = 0; i < DB + 2; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == DB + 1) v = stop;
      else v = b[i-1];
      for (int t = 0; t < OS; t++) begin
        tick();
        rx_in = (glitch && i == 3 && t == OS / 2)
                ? 1'b1 : v;
      end
    end
  endtask

  logic [DB-1:0] last_good = '0;
  bit            prev_pulse = 1'b0;

  // Monitor: pop and compare on every output pulse
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_good  = '0;
        prev_pulse = 1'b0;
      end else begin
        if (valid || frame_err) begin
          chk("exclusive", valid & frame_err, 0);
          chk("pulse_width", prev_pulse, 0);
          chk("expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("kind", frame_err, e.is_err);
            if (!e.is_err) begin
              chk("rdata", rdata, e.data);
              last_good = e.data;
            end else begin
              chk("rdata_hold", rdata, last_good);
            end
          end
        end
        prev_pulse = valid || frame_err;
      end
    end
  end

  initial begin
    logic [DB-1:0] pb;
    logic [DB-1:0] rb;
    bit            st;
    int            w;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(20);

    send(8'hA5, 1'b1, 1'b0);
    idle(5);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(5);
    send(8'h3C, 1'b0, 1'b0);
    idle(20);

    for (int t = 0; t < 4; t++) begin
      tick();
      rx_in = 1'b0;
    end
    chk("short_busy", busy, 1);
    tick();
    rx_in = 1'b1;
    idle(14);
    chk("short_idle", busy, 0);

    pb = 8'h81;
    for (int i = 0; i < 5; i++) begin
      for (int t = 0; t < OS; t++) begin
        tick();
        rx_in = (i == 0) ? 1'b0 : pb[i-1];
      end
    end
    repeat (OS / 2) begin
      tick();
      rx_in = pb[4];
    end
    chk("mid_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdata", rdata, 0);
    rst_n = 1'b1;
    idle(20);
    send(8'h42, 1'b1, 1'b0);
    idle(5);

    send(8'h00, 1'b1, 1'b1);
    idle(5);

    for (int n = 0; n < 24; n++) begin
      rb = DB'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send(rb, st, 1'b0);
      if (!st) idle($urandom_range(4, 20));
      else idle($urandom_range(0, 10));
    end

    w = 0;
    while (exp_q.size() != 0 && w < 4000) begin
      @(posedge clk);
      w++;
    end
    idle(4);
    chk("drain", exp_q.size(), 0);
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
